stack_ctrl: RTL and testbench

- Sequencer between the core's execute stage and internal RAM for stack traffic: PUSH, POP, CALL (push PC) and RET (pop PC).
- Consumes the current stack pointer from the SP register (sp_in) and drives the RAM stack-select code (ram_sel) that makes the SP register increment or decrement.
- Also drives the internal-RAM address, data and strobes for each stack byte, and returns popped data / return PC to the core.

---
 rtl/stack_ctrl.sv | 142 ++++++++++++++
 tb/tb_stack_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences PUSH / POP / CALL / RET between the execute stage
// and internal RAM. The SP register lives outside this block. It reacts to
// ram_sel by stepping SP by one. This block tells it when to step, drives
// the RAM strobes for each stack byte, and hands popped data or the return
// PC back to the core.
//
// Ports
//   clock, reset        rising-edge clock, async active-high reset
//   start, op, data_in  request; op 00 PUSH, 01 POP, 10 CALL, 11 RET
//   sp_in               current SP
//   ram_rdata           RAM read data, valid the cycle after ram_re
//   ram_sel             SP control code (idle / increment / decrement)
//   ram_addr/wdata/we/re internal RAM access
//   busy, done          sequence in flight / one-cycle completion pulse
//   pop_data, pc_out    POP result / RET result, each held until the next one
//   stack_err           overflow or underflow flag, pulses with done
module stack_ctrl #(
    parameter logic [3:0] SEL_IDLE     = 4'h0,
    parameter logic [3:0] SEL_WR_STACK = 4'h1,
    parameter logic [3:0] SEL_RD_STACK = 4'h2,
    parameter logic [7:0] SP_FLOOR     = 8'h07
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] data_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  ram_rdata,
    output logic [3:0]  ram_sel,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pop_data,
    output logic [15:0] pc_out,
    output logic        stack_err
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_INC, S_WR, S_RD, S_CAP, S_DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [15:0] data_q;
    logic        byte_idx;   // 0 = first byte of CALL/RET, 1 = second
    logic        err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= OP_PUSH;
            data_q   <= '0;
            byte_idx <= 1'b0;
            err_q    <= 1'b0;
            pop_data <= '0;
            pc_out   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q     <= op;
                    data_q   <= data_in;
                    byte_idx <= 1'b0;
                    err_q    <= 1'b0;
                end
                // The SP register wraps FFh->00h when this increment lands.
                S_INC: if (sp_in == 8'hFF) err_q <= 1'b1;
                S_WR:  if (op_q == OP_CALL && !byte_idx) byte_idx <= 1'b1;
                // The read still happens at or below the floor; only the
                // error is recorded.
                S_RD:  if (sp_in <= SP_FLOOR) err_q <= 1'b1;
                S_CAP: begin
                    if (op_q == OP_POP) begin
                        pop_data <= ram_rdata;
                    end else if (!byte_idx) begin
                        pc_out[15:8] <= ram_rdata;   // PCH sits on top
                        byte_idx     <= 1'b1;
                    end else begin
                        pc_out[7:0]  <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        ram_sel   = SEL_IDLE;
        ram_addr  = 8'h00;
        ram_wdata = 8'h00;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        stack_err = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (op == OP_PUSH || op == OP_CALL) ? S_INC : S_RD;
            end
            S_INC: begin
                ram_sel  = SEL_WR_STACK;
                state_nx = S_WR;
            end
            S_WR: begin
                ram_we    = 1'b1;
                ram_addr  = sp_in;
                // CALL writes PCL first, then PCH.
                ram_wdata = (op_q == OP_CALL && byte_idx) ? data_q[15:8] : data_q[7:0];
                state_nx  = (op_q == OP_CALL && !byte_idx) ? S_INC : S_DONE;
            end
            S_RD: begin
                ram_re   = 1'b1;
                ram_addr = sp_in;
                state_nx = S_CAP;
            end
            S_CAP: begin
                ram_sel  = SEL_RD_STACK;
                state_nx = (op_q == OP_RET && !byte_idx) ? S_RD : S_DONE;
            end
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                stack_err = err_q;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl. It includes a behavioural SP register, which
// steps on ram_sel and clamps at the floor, and a RAM with a one-cycle read.
module tb_stack_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] data_in = 16'h0;
    logic [7:0]  sp_in;
    logic [7:0]  ram_rdata;
    logic [3:0]  ram_sel;
    logic [7:0]  ram_addr, ram_wdata;
    logic        ram_we, ram_re, busy, done, stack_err;
    logic [7:0]  pop_data;
    logic [15:0] pc_out;

    logic        sp_load = 1'b0;
    logic [7:0]  sp_val  = 8'h00;
    logic [7:0]  mem [256];
    int          we_cnt = 0, re_cnt = 0;
    int          nchk = 0, nfail = 0;

    stack_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .data_in(data_in),
        .sp_in(sp_in), .ram_rdata(ram_rdata), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re), .busy(busy),
        .done(done), .pop_data(pop_data), .pc_out(pc_out), .stack_err(stack_err)
    );

    always #5 clock = ~clock;

    // SP register model
    always @(posedge clock or posedge reset) begin
        if (reset)                            sp_in <= 8'h07;
        else if (sp_load)                     sp_in <= sp_val;
        else if (ram_sel == 4'h1)             sp_in <= sp_in + 8'h01;
        else if (ram_sel == 4'h2 && sp_in > 8'h07) sp_in <= sp_in - 8'h01;
    end

    // RAM model
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    always @(negedge clock) begin
        if (ram_we) we_cnt++;
        if (ram_re) re_cnt++;
        if (ram_we && ram_re) begin
            nchk++; nfail++;
            $display("FAIL we_re_overlap: both strobes high at %0t", $time);
        end
    end

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic do_start(input logic [1:0] o, input logic [15:0] d);
        start = 1'b1; op = o; data_in = d;
        tick();
        start = 1'b0;
    endtask

    task automatic load_sp(input logic [7:0] v);
        sp_load = 1'b1; sp_val = v;
        tick();
        sp_load = 1'b0;
    endtask

    task automatic test_reset;
        tick(); tick();
        nchk++; if ({ram_sel, ram_addr, ram_wdata, ram_we, ram_re, busy, done, stack_err} !== 27'h0) begin
            nfail++; $display("FAIL reset_outputs: got %h want 0",
                {ram_sel, ram_addr, ram_wdata, ram_we, ram_re, busy, done, stack_err}); end
        nchk++; if ({pop_data, pc_out} !== 24'h0) begin
            nfail++; $display("FAIL reset_results: got %h want 0", {pop_data, pc_out}); end
        reset = 1'b0;
        tick();
        nchk++; if (busy !== 1'b0 || done !== 1'b0) begin
            nfail++; $display("FAIL reset_idle: busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_push;
        do_start(2'b00, 16'h00A5);
        nchk++; if (ram_sel !== 4'h1 || busy !== 1'b1 || ram_we !== 1'b0) begin
            nfail++; $display("FAIL push_inc: sel %h busy %b we %b want 1 1 0", ram_sel, busy, ram_we); end
        tick();
        nchk++; if (ram_we !== 1'b1 || ram_addr !== 8'h08 || ram_wdata !== 8'hA5 || ram_sel !== 4'h0) begin
            nfail++; $display("FAIL push_wr: we %b addr %h wdata %h sel %h want 1 08 a5 0",
                ram_we, ram_addr, ram_wdata, ram_sel); end
        tick();
        nchk++; if (done !== 1'b1 || stack_err !== 1'b0 || busy !== 1'b0) begin
            nfail++; $display("FAIL push_done: done %b err %b busy %b want 1 0 0", done, stack_err, busy); end
        tick();
        nchk++; if (done !== 1'b0 || mem[8'h08] !== 8'hA5) begin
            nfail++; $display("FAIL push_after: done %b mem08 %h want 0 a5", done, mem[8'h08]); end
    endtask

    task automatic test_pop;
        do_start(2'b01, 16'h0000);
        nchk++; if (ram_re !== 1'b1 || ram_addr !== 8'h08 || ram_sel !== 4'h0) begin
            nfail++; $display("FAIL pop_rd: re %b addr %h sel %h want 1 08 0", ram_re, ram_addr, ram_sel); end
        tick();
        nchk++; if (ram_sel !== 4'h2 || ram_re !== 1'b0) begin
            nfail++; $display("FAIL pop_cap: sel %h re %b want 2 0", ram_sel, ram_re); end
        tick();
        nchk++; if (done !== 1'b1 || pop_data !== 8'hA5 || stack_err !== 1'b0 || ram_sel !== 4'h0) begin
            nfail++; $display("FAIL pop_done: done %b data %h err %b sel %h want 1 a5 0 0",
                done, pop_data, stack_err, ram_sel); end
        tick();
    endtask

    task automatic test_call;
        do_start(2'b10, 16'h1234);
        nchk++; if (ram_sel !== 4'h1) begin
            nfail++; $display("FAIL call_inc0: sel %h want 1", ram_sel); end
        tick();
        nchk++; if (ram_we !== 1'b1 || ram_addr !== 8'h08 || ram_wdata !== 8'h34) begin
            nfail++; $display("FAIL call_wr0: we %b addr %h wdata %h want 1 08 34", ram_we, ram_addr, ram_wdata); end
        tick();
        nchk++; if (ram_sel !== 4'h1 || done !== 1'b0) begin
            nfail++; $display("FAIL call_inc1: sel %h done %b want 1 0", ram_sel, done); end
        tick();
        nchk++; if (ram_we !== 1'b1 || ram_addr !== 8'h09 || ram_wdata !== 8'h12) begin
            nfail++; $display("FAIL call_wr1: we %b addr %h wdata %h want 1 09 12", ram_we, ram_addr, ram_wdata); end
        tick();
        nchk++; if (done !== 1'b1 || stack_err !== 1'b0) begin
            nfail++; $display("FAIL call_done: done %b err %b want 1 0", done, stack_err); end
        tick();
    endtask

    task automatic test_ret;
        do_start(2'b11, 16'h0000);
        nchk++; if (ram_re !== 1'b1 || ram_addr !== 8'h09) begin
            nfail++; $display("FAIL ret_rd0: re %b addr %h want 1 09", ram_re, ram_addr); end
        tick();
        nchk++; if (ram_sel !== 4'h2) begin
            nfail++; $display("FAIL ret_cap0: sel %h want 2", ram_sel); end
        tick();
        nchk++; if (ram_re !== 1'b1 || ram_addr !== 8'h08) begin
            nfail++; $display("FAIL ret_rd1: re %b addr %h want 1 08", ram_re, ram_addr); end
        tick();
        nchk++; if (ram_sel !== 4'h2) begin
            nfail++; $display("FAIL ret_cap1: sel %h want 2", ram_sel); end
        tick();
        nchk++; if (done !== 1'b1 || pc_out !== 16'h1234 || stack_err !== 1'b0) begin
            nfail++; $display("FAIL ret_done: done %b pc %h err %b want 1 1234 0", done, pc_out, stack_err); end
        tick();
    endtask

    task automatic test_overflow;
        load_sp(8'hFF);
        do_start(2'b00, 16'h005A);
        tick();
        nchk++; if (ram_we !== 1'b1 || ram_addr !== 8'h00 || ram_wdata !== 8'h5A) begin
            nfail++; $display("FAIL ovf_wr: we %b addr %h wdata %h want 1 00 5a", ram_we, ram_addr, ram_wdata); end
        tick();
        nchk++; if (done !== 1'b1 || stack_err !== 1'b1) begin
            nfail++; $display("FAIL ovf_done: done %b err %b want 1 1", done, stack_err); end
        tick();
        nchk++; if (stack_err !== 1'b0) begin
            nfail++; $display("FAIL ovf_err_pulse: err %b want 0", stack_err); end
    endtask

    task automatic test_underflow;
        load_sp(8'h06);
        do_start(2'b00, 16'h003C);   // lands at 07h, SP becomes 07h
        tick(); tick(); tick();
        do_start(2'b01, 16'h0000);
        nchk++; if (ram_re !== 1'b1 || ram_addr !== 8'h07) begin
            nfail++; $display("FAIL unf_rd: re %b addr %h want 1 07", ram_re, ram_addr); end
        tick(); tick();
        nchk++; if (done !== 1'b1 || stack_err !== 1'b1 || pop_data !== 8'h3C) begin
            nfail++; $display("FAIL unf_done: done %b err %b data %h want 1 1 3c", done, stack_err, pop_data); end
        tick();
    endtask

    task automatic test_busy_ignore;
        int we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        do_start(2'b00, 16'h0011);
        start = 1'b1; op = 2'b01; data_in = 16'h00EE;   // held through INC/WR
        nchk++; if (ram_sel !== 4'h1) begin
            nfail++; $display("FAIL busy_inc: sel %h want 1", ram_sel); end
        tick();
        nchk++; if (ram_addr !== 8'h08 || ram_wdata !== 8'h11) begin
            nfail++; $display("FAIL busy_wr: addr %h wdata %h want 08 11", ram_addr, ram_wdata); end
        start = 1'b0;
        tick();
        nchk++; if (done !== 1'b1) begin
            nfail++; $display("FAIL busy_done: done %b want 1", done); end
        tick(); tick();
        nchk++; if (busy !== 1'b0 || we_cnt - we0 !== 1 || re_cnt - re0 !== 0) begin
            nfail++; $display("FAIL busy_strobes: busy %b we %0d re %0d want 0 1 0",
                busy, we_cnt - we0, re_cnt - re0); end
    endtask

    task automatic test_reset_mid;
        int sawdone;
        load_sp(8'h07);
        do_start(2'b10, 16'hABCD);
        tick();
        nchk++; if (ram_we !== 1'b1 || ram_wdata !== 8'hCD) begin
            nfail++; $display("FAIL mid_wr0: we %b wdata %h want 1 cd", ram_we, ram_wdata); end
        reset = 1'b1;
        #1;
        nchk++; if ({ram_sel, ram_addr, ram_wdata, ram_we, ram_re, busy, done, stack_err} !== 27'h0
                    || {pop_data, pc_out} !== 24'h0) begin
            nfail++; $display("FAIL mid_async: got %h %h want 0 0",
                {ram_sel, ram_addr, ram_wdata, ram_we, ram_re, busy, done, stack_err}, {pop_data, pc_out}); end
        sawdone = 0;
        repeat (3) begin tick(); if (done) sawdone++; end
        reset = 1'b0;
        repeat (3) begin tick(); if (done) sawdone++; end
        nchk++; if (sawdone !== 0 || busy !== 1'b0) begin
            nfail++; $display("FAIL mid_nodone: done pulses %0d busy %b want 0 0", sawdone, busy); end
        do_start(2'b00, 16'h0077);
        nchk++; if (done !== 1'b0 || ram_sel !== 4'h1) begin
            nfail++; $display("FAIL post_inc: done %b sel %h want 0 1", done, ram_sel); end
        tick();
        nchk++; if (ram_addr !== 8'h08 || ram_wdata !== 8'h77 || done !== 1'b0) begin
            nfail++; $display("FAIL post_wr: addr %h wdata %h done %b want 08 77 0", ram_addr, ram_wdata, done); end
        tick();
        nchk++; if (done !== 1'b1 || stack_err !== 1'b0) begin
            nfail++; $display("FAIL post_done: done %b err %b want 1 0", done, stack_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_call();
        test_ret();
        test_overflow();
        test_underflow();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
